connect4_pixel_renderer: RTL and testbench
==========================================

# connect4_pixel_renderer

Pipelined pixel-colour stage that sits directly downstream of the 640x480 VGA timing generator. It consumes that generator's pixel coordinates, video enable and sync signals, then drives the 8-bit RGB DAC pins. It draws the 7x6 Connect-4 board, the player discs, a cursor disc above the selected column and blinking winning cells. Board state is snapshotted once per frame so that game-logic updates never tear the image.

## Interface
Parameters:
- BOARD_X0, 96: left edge of the board, in pixels.
- BOARD_Y0, 64: top edge of the board, in pixels; the cursor row occupies y 0..63.
- DISC_R2, 784: disc radius squared (radius 28).
- BLINK_BIT, 4: frame-counter bit that drives the win blink.

Ports:
- dclk  in  1  pixel clock, 25 MHz.
- clr  in  1  reset, asynchronous, active-high.
- x_pixel  in  11  pixel x from the timing generator.
- y_pixel  in  11  pixel y from the timing generator.
- vid_enable  in  1  active-video flag.
- hsync_in  in  1  hsync from the timing generator, active-low.
- vsync_in  in  1  vsync from the timing generator, active-low.
- board_state  in  84  42 cells x 2 bits; cell index = row*7+col, row 0 = bottom. Codes: 00 empty, 01 P1, 10 P2, 11 rendered as empty.
- win_mask  in  42  1 = winning cell, same indexing as board_state.
- cursor_col  in  3  cursor column 0..6; values 7 and above mean no cursor.
- cur_player  in  2  01 or 10 selects the cursor colour; any other value means no cursor.
- red  out  3
- green  out  3
- blue  out  2
- hsync_out  out  1  active-low, aligned to RGB.
- vsync_out  out  1  active-low, aligned to RGB.

## Operation
- Frame snapshot:
  - Register vsync_in and detect its falling edge.
  - On that edge, latch board_state, win_mask, cursor_col and cur_player into shadow registers.
  - Increment the 5-bit frame_cnt on the same edge.
  - blink = frame_cnt[BLINK_BIT], so blink toggles every 16 frames.
  - All rendering uses the shadow registers only.
- Geometry:
  - gx = x - BOARD_X0, gy = y - BOARD_Y0.
  - The board spans gx 0..447 and gy 0..383; cells are 64x64.
  - Screen column = gx[8:6]. Screen row sr = gy[8:6]. Board row = 5 - sr.
  - Local coordinates within a cell: lx = gx[5:0], ly = gy[5:0].
  - dx = lx - 32 and dy = ly - 32 are signed 7-bit; each square is 12 bits unsigned; sum = 13 bits.
  - in_disc = (dx² + dy²) <= DISC_R2.
- Cursor region: y 0..63 and x inside the board span. Local coordinates use the same 64-px grid.
- Colour priority, first match wins:
  1. vid_enable low: black 0x00.
  2. Cursor region: in_disc, column == cursor_col and cursor valid gives the player colour; otherwise black.
  3. Outside the board: black.
  4. Inside a board cell but not in_disc: board blue 0x03.
  5. In a disc with win bit set and blink = 1: white 0xFF.
  6. Disc code 01: red 0xE0. Disc code 10: yellow 0xFC. Disc code 00 or 11: black 0x00.
- RGB packing is {red, green, blue}.
- Reset clears all pipeline registers, shadow registers and frame_cnt. hsync_out and vsync_out reset to 1; RGB resets to 0.
- A reset asserted mid-frame blanks the output immediately. Rendering resumes with the cleared (empty) shadow state until the next vsync falling edge.

## Timing
- Three-stage pipeline:
  - S1: register the inputs; compute gx, gy, region flags and cell index.
  - S2: compute the squares; fetch the cell code and win bit.
  - S3: compare against DISC_R2, select the colour, register RGB.
- Latency from x_pixel/y_pixel/vid_enable to RGB is 3 dclk.
- hsync_in and vsync_in pass through a 4-stage delay: 3 stages for the pipeline plus 1 to cover the timing generator's registered coordinates. This makes the syncs align with RGB at the pins.
- The snapshot takes effect on the cycle after the detected vsync falling edge. This always falls in blanking, so no visible pixel mixes two snapshots.
- Input changes to board_state mid-frame have no visible effect until the next frame.

## Structure
- Shared package `connect4_pkg`:
  - Cell codes EMPTY, P1 and P2.
  - Colour constants BLACK, BLUE, RED, YELLOW and WHITE.
  - COLS=7, ROWS=6 and CELL_SHIFT=6.
- One natural sub-module, `disc_hit`: a 2-stage pipelined dx²+dy² <= R² comparator, taking lx/ly in and giving in_disc out.

## Test plan
- Reset: assert clr mid-frame -> RGB = 0x00, hsync_out = vsync_out = 1, frame_cnt = 0. After release, every board cell renders black.
- Disc edge: board_state cell (row 0, col 0) = 01, x = 96+60, y = 64+5*64+32 -> RGB 0xE0. At x = 96+61 -> 0x03. Latency is exactly 3 cycles.
- Cursor: cursor_col = 3, cur_player = 10, x = 96+3*64+32, y = 32 -> 0xFC. With cursor_col = 7 -> 0x00.
- Snapshot hold: change board_state mid-frame -> output unchanged until after the next vsync falling edge, then the new value is shown.
- Blink: win_mask bit 0 set on a P2 cell -> colour 0xFC for frames 0-15, 0xFF for frames 16-31, then wraps.
- Alignment: hsync_out equals hsync_in delayed 4 cycles; vid_enable = 0 -> RGB 0x00 whatever the coordinates.

Source files
------------

// File: rtl/connect4_pkg.sv
// Shared cell codes, palette and board geometry for the Connect-4 pixel renderer.
package connect4_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        P1    = 2'b01,
        P2    = 2'b10
    } cell_e;

    localparam logic [7:0] BLACK  = 8'h00;
    localparam logic [7:0] BLUE   = 8'h03;
    localparam logic [7:0] RED    = 8'hE0;
    localparam logic [7:0] YELLOW = 8'hFC;
    localparam logic [7:0] WHITE  = 8'hFF;

    localparam int COLS       = 7;
    localparam int ROWS       = 6;
    localparam int CELL_SHIFT = 6;

    // Code 11 is undefined game state and renders like an empty cell.
    function automatic logic [7:0] player_colour(input logic [1:0] code);
        case (code)
            P1:      return RED;
            P2:      return YELLOW;
            default: return BLACK;
        endcase
    endfunction

endpackage

// File: rtl/connect4_pixel_renderer_disc_hit.sv
// Two-stage dx^2+dy^2 <= R^2 test against the centre of a 64x64 cell.
module disc_hit #(
    parameter int unsigned R2 = 784
) (
    input  logic       dclk,
    input  logic       clr,
    input  logic [5:0] lx,
    input  logic [5:0] ly,
    output logic       in_disc
);

    logic [5:0]  lx_q, lx_d, ly_q, ly_d;
    logic [12:0] sum_q, sum_d;

    // Square via magnitude so the product stays 12 bits unsigned (max 32^2).
    function automatic logic [11:0] sq_off(input logic [5:0] l);
        logic signed [6:0] d;
        logic [5:0]        m;
        d = signed'({1'b0, l}) - 7'sd32;
        m = d[6] ? 6'(-d) : 6'(d);
        return 12'(m) * 12'(m);
    endfunction

    always_comb begin
        lx_d  = lx;
        ly_d  = ly;
        sum_d = 13'(sq_off(lx_q)) + 13'(sq_off(ly_q));
    end

    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            lx_q  <= '0;
            ly_q  <= '0;
            sum_q <= '0;
        end else begin
            lx_q  <= lx_d;
            ly_q  <= ly_d;
            sum_q <= sum_d;
        end
    end

    assign in_disc = sum_q <= 13'(R2);

endmodule

// File: rtl/connect4_pixel_renderer.sv
// Three-stage pixel colour pipeline for the 7x6 Connect-4 board on 640x480 VGA,
// rendering from per-frame shadow copies of the game state.
module connect4_pixel_renderer
    import connect4_pkg::*;
#(
    parameter int unsigned BOARD_X0  = 96,
    parameter int unsigned BOARD_Y0  = 64,
    parameter int unsigned DISC_R2   = 784,
    parameter int unsigned BLINK_BIT = 4
) (
    input  logic        dclk,
    input  logic        clr,
    input  logic [10:0] x_pixel,
    input  logic [10:0] y_pixel,
    input  logic        vid_enable,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [83:0] board_state,
    input  logic [41:0] win_mask,
    input  logic [2:0]  cursor_col,
    input  logic [1:0]  cur_player,
    output logic [2:0]  red,
    output logic [2:0]  green,
    output logic [1:0]  blue,
    output logic        hsync_out,
    output logic        vsync_out
);

    // Frame snapshot state
    logic        vs_last_q, vs_last_d, vsync_fall, blink;
    logic [83:0] sh_board_q, sh_board_d;
    logic [41:0] sh_win_q, sh_win_d;
    logic [2:0]  sh_col_q, sh_col_d;
    logic [1:0]  sh_player_q, sh_player_d;
    logic [4:0]  frame_cnt_q, frame_cnt_d;

    // Pipeline state
    logic [10:0] gx, gy;
    logic        in_x, in_y, cur_valid, in_disc;
    logic [2:0]  brow;
    logic        vid_s1_q, vid_s1_d, cur_s1_q, cur_s1_d, brd_s1_q, brd_s1_d;
    logic [2:0]  col_s1_q, col_s1_d;
    logic [5:0]  idx_s1_q, idx_s1_d;
    logic        vid_s2_q, vid_s2_d, cur_s2_q, cur_s2_d, brd_s2_q, brd_s2_d;
    logic        win_s2_q, win_s2_d;
    logic [1:0]  code_s2_q, code_s2_d;
    logic [7:0]  cur_rgb_s2_q, cur_rgb_s2_d;
    logic [7:0]  rgb_q, rgb_d;
    logic [3:0]  hs_pipe_q, hs_pipe_d, vs_pipe_q, vs_pipe_d;

    always_comb begin
        vsync_fall  = vs_last_q & ~vsync_in;
        vs_last_d   = vsync_in;
        sh_board_d  = sh_board_q;
        sh_win_d    = sh_win_q;
        sh_col_d    = sh_col_q;
        sh_player_d = sh_player_q;
        frame_cnt_d = frame_cnt_q;
        if (vsync_fall) begin
            sh_board_d  = board_state;
            sh_win_d    = win_mask;
            sh_col_d    = cursor_col;
            sh_player_d = cur_player;
            frame_cnt_d = frame_cnt_q + 5'd1;
        end
    end

    assign blink = frame_cnt_q[BLINK_BIT];

    // S1: geometry. Coordinates left of / above the board wrap to large values.
    always_comb begin
        gx       = x_pixel - 11'(BOARD_X0);
        gy       = y_pixel - 11'(BOARD_Y0);
        in_x     = gx < 11'(COLS << CELL_SHIFT);
        in_y     = gy < 11'(ROWS << CELL_SHIFT);
        brow     = 3'(ROWS - 1) - gy[CELL_SHIFT +: 3];
        vid_s1_d = vid_enable;
        cur_s1_d = in_x && (y_pixel < 11'(BOARD_Y0));
        brd_s1_d = in_x && in_y;
        col_s1_d = gx[CELL_SHIFT +: 3];
        idx_s1_d = brd_s1_d ? 6'(brow) * 6'(COLS) + 6'(gx[CELL_SHIFT +: 3]) : 6'd0;
    end

    disc_hit #(.R2(DISC_R2)) u_disc_hit (
        .dclk    (dclk),
        .clr     (clr),
        .lx      (gx[5:0]),
        .ly      (gy[5:0]),
        .in_disc (in_disc)
    );

    // S2: cell fetch from the shadow copy; cursor colour resolved early.
    always_comb begin
        cur_valid    = (sh_col_q < 3'(COLS)) && (sh_player_q == P1 || sh_player_q == P2);
        vid_s2_d     = vid_s1_q;
        cur_s2_d     = cur_s1_q;
        brd_s2_d     = brd_s1_q;
        code_s2_d    = sh_board_q[{idx_s1_q, 1'b0} +: 2];
        win_s2_d     = sh_win_q[idx_s1_q] & blink;
        cur_rgb_s2_d = (cur_valid && col_s1_q == sh_col_q) ? player_colour(sh_player_q) : BLACK;
    end

    // S3: colour priority.
    always_comb begin
        rgb_d = BLACK;
        if (!vid_s2_q)
            rgb_d = BLACK;
        else if (cur_s2_q)
            rgb_d = in_disc ? cur_rgb_s2_q : BLACK;
        else if (!brd_s2_q)
            rgb_d = BLACK;
        else if (!in_disc)
            rgb_d = BLUE;
        else if (win_s2_q)
            rgb_d = WHITE;
        else
            rgb_d = player_colour(code_s2_q);
        hs_pipe_d = {hs_pipe_q[2:0], hsync_in};
        vs_pipe_d = {vs_pipe_q[2:0], vsync_in};
    end

    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            vs_last_q    <= 1'b1;
            sh_board_q   <= '0;
            sh_win_q     <= '0;
            sh_col_q     <= '0;
            sh_player_q  <= '0;
            frame_cnt_q  <= '0;
            vid_s1_q     <= 1'b0;
            cur_s1_q     <= 1'b0;
            brd_s1_q     <= 1'b0;
            col_s1_q     <= '0;
            idx_s1_q     <= '0;
            vid_s2_q     <= 1'b0;
            cur_s2_q     <= 1'b0;
            brd_s2_q     <= 1'b0;
            win_s2_q     <= 1'b0;
            code_s2_q    <= '0;
            cur_rgb_s2_q <= '0;
            rgb_q        <= '0;
            hs_pipe_q    <= '1;
            vs_pipe_q    <= '1;
        end else begin
            vs_last_q    <= vs_last_d;
            sh_board_q   <= sh_board_d;
            sh_win_q     <= sh_win_d;
            sh_col_q     <= sh_col_d;
            sh_player_q  <= sh_player_d;
            frame_cnt_q  <= frame_cnt_d;
            vid_s1_q     <= vid_s1_d;
            cur_s1_q     <= cur_s1_d;
            brd_s1_q     <= brd_s1_d;
            col_s1_q     <= col_s1_d;
            idx_s1_q     <= idx_s1_d;
            vid_s2_q     <= vid_s2_d;
            cur_s2_q     <= cur_s2_d;
            brd_s2_q     <= brd_s2_d;
            win_s2_q     <= win_s2_d;
            code_s2_q    <= code_s2_d;
            cur_rgb_s2_q <= cur_rgb_s2_d;
            rgb_q        <= rgb_d;
            hs_pipe_q    <= hs_pipe_d;
            vs_pipe_q    <= vs_pipe_d;
        end
    end

    assign {red, green, blue} = rgb_q;
    assign hsync_out = hs_pipe_q[3];
    assign vsync_out = vs_pipe_q[3];

endmodule

// File: tb/tb_connect4_pixel_renderer.sv
// Directed bench for connect4_pixel_renderer: geometry, cursor, snapshot, blink, sync delay, reset.
module tb_connect4_pixel_renderer;

    logic        dclk = 1'b0;
    logic        clr;
    logic [10:0] x_pixel, y_pixel;
    logic        vid_enable, hsync_in, vsync_in;
    logic [83:0] board_state;
    logic [41:0] win_mask;
    logic [2:0]  cursor_col;
    logic [1:0]  cur_player;
    logic [2:0]  red, green;
    logic [1:0]  blue;
    logic        hsync_out, vsync_out;
    logic [7:0]  rgb;

    int         n_chk = 0;
    int         n_fail = 0;
    logic [4:0] frames;

    always #20 dclk = ~dclk;
    assign rgb = {red, green, blue};

    connect4_pixel_renderer dut (
        .dclk        (dclk),
        .clr         (clr),
        .x_pixel     (x_pixel),
        .y_pixel     (y_pixel),
        .vid_enable  (vid_enable),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .board_state (board_state),
        .win_mask    (win_mask),
        .cursor_col  (cursor_col),
        .cur_player  (cur_player),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic render(input string tag, input int x, input int y, input logic ve,
                          input logic [7:0] exp);
        @(negedge dclk);
        x_pixel    = 11'(x);
        y_pixel    = 11'(y);
        vid_enable = ve;
        repeat (3) @(posedge dclk);
        @(negedge dclk);
        chk(tag, 32'(rgb), 32'(exp));
    endtask

    task automatic vpulse();
        @(negedge dclk);
        vsync_in = 1'b0;
        @(negedge dclk);
        vsync_in = 1'b1;
        frames = frames + 5'd1;
    endtask

    function automatic logic [7:0] blink_exp(input logic [4:0] f);
        return f[4] ? 8'hFF : 8'hFC;
    endfunction

    initial begin
        clr = 1'b1;
        x_pixel = 11'd0; y_pixel = 11'd0; vid_enable = 1'b1;
        hsync_in = 1'b1; vsync_in = 1'b1;
        board_state = '0; board_state[1:0] = 2'b01;
        win_mask = '0; cursor_col = 3'd7; cur_player = 2'b00;
        frames = 5'd0;
        repeat (3) @(negedge dclk);
        chk("reset_rgb", 32'(rgb), 32'h00);
        chk("reset_hs", 32'(hsync_out), 32'd1);
        chk("reset_vs", 32'(vsync_out), 32'd1);
        clr = 1'b0;

        // Shadow still empty: cell 0 input is P1 but not yet snapshotted
        render("pre_snap_disc", 128, 416, 1'b1, 8'h00);
        render("pre_snap_board", 157, 416, 1'b1, 8'h03);

        vpulse();
        // Exact 3-cycle latency
        @(negedge dclk);
        x_pixel = 11'd156; y_pixel = 11'd416; vid_enable = 1'b0;
        repeat (3) @(negedge dclk);
        vid_enable = 1'b1;
        repeat (2) @(posedge dclk);
        @(negedge dclk);
        chk("latency_2cyc", 32'(rgb), 32'h00);
        @(negedge dclk);
        chk("latency_3cyc", 32'(rgb), 32'hE0);

        render("disc_edge_in", 156, 416, 1'b1, 8'hE0);
        render("disc_edge_out", 157, 416, 1'b1, 8'h03);
        render("vid_off", 156, 416, 1'b0, 8'h00);
        render("left_outside", 50, 200, 1'b1, 8'h00);
        render("right_last_px", 543, 64, 1'b1, 8'h03);
        render("right_outside", 544, 64, 1'b1, 8'h00);
        render("bottom_last_px", 128, 447, 1'b1, 8'h03);
        render("bottom_outside", 128, 448, 1'b1, 8'h00);

        cursor_col = 3'd3; cur_player = 2'b10;
        vpulse();
        render("cursor_p2", 320, 32, 1'b1, 8'hFC);
        render("cursor_other_col", 256, 32, 1'b1, 8'h00);
        cursor_col = 3'd0; cur_player = 2'b01;
        vpulse();
        render("cursor_p1", 128, 32, 1'b1, 8'hE0);
        render("cursor_outside_x", 50, 32, 1'b1, 8'h00);
        cursor_col = 3'd3; cur_player = 2'b11;
        vpulse();
        render("cursor_bad_player", 320, 32, 1'b1, 8'h00);
        cursor_col = 3'd7; cur_player = 2'b10;
        vpulse();
        render("cursor_col7", 320, 32, 1'b1, 8'h00);

        // Mid-frame game update must not show until the next frame
        board_state[1:0] = 2'b10;
        board_state[3:2] = 2'b11;
        win_mask[0] = 1'b1;
        render("hold_old_cell", 128, 416, 1'b1, 8'hE0);
        vpulse();
        render("new_cell_p2", 128, 416, 1'b1, blink_exp(frames));
        render("code11_black", 192, 416, 1'b1, 8'h00);

        while (frames != 5'd15) vpulse();
        render("blink_f15", 128, 416, 1'b1, blink_exp(frames));
        vpulse();
        render("blink_f16", 128, 416, 1'b1, blink_exp(frames));

        // hsync passes through 4 stages
        @(negedge dclk);
        hsync_in = 1'b0;
        @(negedge dclk);
        hsync_in = 1'b1;
        repeat (2) @(negedge dclk);
        chk("hs_delay3", 32'(hsync_out), 32'd1);
        @(negedge dclk);
        chk("hs_delay4", 32'(hsync_out), 32'd0);
        @(negedge dclk);
        chk("hs_delay5", 32'(hsync_out), 32'd1);

        // Asynchronous reset in the middle of a white pixel run
        @(negedge dclk);
        hsync_in = 1'b0;
        repeat (5) @(negedge dclk);
        chk("pre_reset_rgb", 32'(rgb), 32'hFF);
        #5 clr = 1'b1;
        #1;
        chk("async_rst_rgb", 32'(rgb), 32'h00);
        chk("async_rst_hs", 32'(hsync_out), 32'd1);
        chk("async_rst_vs", 32'(vsync_out), 32'd1);
        @(negedge dclk);
        clr = 1'b0;
        hsync_in = 1'b1;
        frames = 5'd0;
        render("post_rst_cell", 128, 416, 1'b1, 8'h00);
        render("post_rst_board", 157, 416, 1'b1, 8'h03);
        vpulse();
        render("post_rst_frame1", 128, 416, 1'b1, blink_exp(frames));

        while (frames != 5'd16) vpulse();
        render("blink_r16", 128, 416, 1'b1, blink_exp(frames));
        while (frames != 5'd31) vpulse();
        render("blink_r31", 128, 416, 1'b1, blink_exp(frames));
        vpulse();
        render("blink_wrap", 128, 416, 1'b1, blink_exp(frames));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
